// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: instruction field layout, opcodes
// and the fetch-unit state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter: +4 sequencing, redirect load with word alignment.
// A redirect always wins over sequential advance.
module pc_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ALIGN_MASK;
        end else if (advance) begin
            pc <= pc + ADDR_W'(4);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one memory request at a time, captures the
// returned word and hands it to decode; supports PC redirects in any state.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm,
    output logic [ADDR_W-1:0]  pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    fetch_state_e       state;
    logic               discard;
    logic               req_valid_q;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic               req_fire;
    logic               pc_advance;

    assign req_fire   = req_valid_q & imem_req_ready;
    assign pc_advance = (state == FETCH_HOLD) & instr_ready;

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk            (clk),
        .rst_n          (rst_n),
        .advance        (pc_advance),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc)
    );

    // Handshake outputs are registered alongside the state they belong to, so
    // req_valid stays low for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH_REQ;
            discard       <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (req_fire) begin
                        state       <= FETCH_WAIT;
                        req_valid_q <= 1'b0;
                        discard     <= redirect_valid;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (discard || redirect_valid) begin
                            state       <= FETCH_REQ;
                            req_valid_q <= 1'b1;
                            discard     <= 1'b0;
                        end else begin
                            state         <= FETCH_HOLD;
                            instr_q       <= imem_rsp_data;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect_valid || instr_ready) begin
                        state         <= FETCH_REQ;
                        req_valid_q   <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state         <= FETCH_REQ;
                    discard       <= 1'b0;
                    req_valid_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;

    assign opcode = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign rs     = instr_q[RS_MSB:RS_LSB];
    assign rt     = instr_q[RT_MSB:RT_LSB];
    assign rd     = instr_q[RD_MSB:RD_LSB];
    assign shamt  = instr_q[SHAMT_MSB:SHAMT_LSB];
    assign funct  = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign imm    = instr_q[IMM_MSB:IMM_LSB];

endmodule
